// File: rtl/uart_tx_arb.sv
// Round-robin, packet-aware arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters; drives the TX core start/data and tracks its busy flag.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned HOLD_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_busy_i,
    output logic                   busy_o
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CAND_W  = PTR_W + 1;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned HOLD_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]     gnt_idx, gnt_idx_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [BURST_W-1:0]   burst_cnt, burst_n;
    logic [HOLD_W-1:0]    hold_cnt, hold_n, hold_inc;
    logic                 last_r, last_n;
    logic                 busy_seen, busy_seen_n;
    logic [7:0]           data_n;
    logic                 release_c;

    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [CAND_W-1:0]    cand;

    // Round-robin search starting just after the last released owner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = CAND_W'(rr_ptr) + CAND_W'(i);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!win_found && req_valid_i[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-value logic; release returns the grant and moves the pointer
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        gnt_idx_n   = gnt_idx;
        grant_n     = grant_o;
        burst_n     = burst_cnt;
        hold_n      = hold_cnt;
        last_n      = last_r;
        busy_seen_n = busy_seen;
        data_n      = tx_data_o;
        release_c   = 1'b0;
        hold_inc    = hold_cnt + HOLD_W'(1);

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    gnt_idx_n = win_idx;
                    grant_n   = NUM_REQ'(1) << win_idx;
                    state_n   = S_LOAD;
                end
            end
            S_LOAD: begin
                data_n  = req_data_i[{gnt_idx, 3'b000} +: 8];
                last_n  = req_last_i[gnt_idx];
                burst_n = burst_cnt + BURST_W'(1);
                state_n = S_START;
            end
            S_START: begin
                busy_seen_n = 1'b0;
                state_n     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_busy_i) begin
                    busy_seen_n = 1'b1;
                end else if (busy_seen) begin
                    if (last_r || (burst_cnt == BURST_W'(MAX_BURST))) begin
                        release_c = 1'b1;
                    end else begin
                        hold_n  = '0;
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (req_valid_i[gnt_idx]) begin
                    state_n = S_LOAD;
                end else if (hold_inc == HOLD_W'(HOLD_CYCLES)) begin
                    release_c = 1'b1;
                end else begin
                    hold_n = hold_inc;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (release_c) begin
            rr_ptr_n = gnt_idx;
            grant_n  = '0;
            burst_n  = '0;
            state_n  = S_IDLE;
        end
    end

    // Datapath and registered outputs, derived from the next state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            gnt_idx     <= '0;
            burst_cnt   <= '0;
            hold_cnt    <= '0;
            last_r      <= 1'b0;
            busy_seen   <= 1'b0;
            grant_o     <= '0;
            req_ready_o <= '0;
            tx_data_o   <= 8'h00;
            tx_start_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_n;
            gnt_idx     <= gnt_idx_n;
            burst_cnt   <= burst_n;
            hold_cnt    <= hold_n;
            last_r      <= last_n;
            busy_seen   <= busy_seen_n;
            grant_o     <= grant_n;
            req_ready_o <= (state_n == S_LOAD) ? grant_n : '0;
            tx_data_o   <= data_n;
            tx_start_o  <= (state_n == S_START);
            busy_o      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed timing scenarios plus randomized packet mixes
// scored against a queue-level round-robin model of the arbitration rules.
module tb_uart_tx_arb;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned MAX_BURST   = 16;
    localparam int unsigned HOLD_CYCLES = 10;

    logic                 clk = 1'b0;
    logic                 rstn_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [7:0]           tx_data_o;
    logic                 tx_start_o;
    logic                 tx_busy_i;
    logic                 busy_o;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ     (NUM_REQ),
        .MAX_BURST   (MAX_BURST),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .tx_data_o   (tx_data_o),
        .tx_start_o  (tx_start_o),
        .tx_busy_i   (tx_busy_i),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] src_q [NUM_REQ][$];   // {last, byte} per requester
    logic [8:0] pend_q[NUM_REQ][$];
    logic [8:0] mdl_q [NUM_REQ][$];
    int         exp_owner[$];
    logic [7:0] exp_data[$];
    int         model_ptr;

    int cyc = 0, start_cnt = 0, fall_cnt = 0, fall_cyc = 0, busyo_fall_cyc = 0;
    int ready_pulses = 0, grant_rises = 0, tx_cnt = 0;
    logic prev_busy = 1'b0, prev_busy_o = 1'b0, start_s = 1'b0;
    logic [NUM_REQ-1:0] prev_grant = '0, ready_s = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Output monitor and scoreboard, sampled on the inactive edge
    always @(negedge clk) begin
        cyc++;
        ready_s = req_ready_o;
        start_s = tx_start_o;
        if (rstn_i) begin
            check_eq("grant_onehot0", 32'($onehot0(grant_o)), 32'(1));
            check_eq("ready_onehot0", 32'($onehot0(req_ready_o)), 32'(1));
            check_eq("ready_in_grant", 32'(req_ready_o & ~grant_o), 32'(0));
            check_eq("start_while_busy", 32'(tx_start_o & tx_busy_i), 32'(0));
            if (|req_ready_o) ready_pulses++;
            if ((grant_o != '0) && (prev_grant == '0)) grant_rises++;
            if (prev_busy && !tx_busy_i) begin
                fall_cnt++;
                fall_cyc = cyc;
            end
            if (prev_busy_o && !busy_o) busyo_fall_cyc = cyc;
            if (tx_start_o) begin
                start_cnt++;
                check_eq("start_expected", 32'(exp_owner.size() > 0), 32'(1));
                if (exp_owner.size() > 0) begin
                    check_eq("start_owner", 32'(onehot_idx(grant_o)), 32'(exp_owner.pop_front()));
                    check_eq("start_data", 32'(tx_data_o), 32'(exp_data.pop_front()));
                end
            end
        end
        prev_busy   = tx_busy_i;
        prev_busy_o = busy_o;
        prev_grant  = grant_o;
    end

    // Requester and UART TX core models, updated just after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rstn_i) tx_cnt = 0;
            else if (start_s) tx_cnt = $urandom_range(2, 5);
            else if (tx_cnt > 0) tx_cnt--;
            tx_busy_i = (tx_cnt != 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (ready_s[k] && (src_q[k].size() > 0)) void'(src_q[k].pop_front());
            end
            req_valid_i = '0;
            req_last_i  = '0;
            req_data_i  = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (src_q[k].size() > 0) begin
                    req_valid_i[k]       = 1'b1;
                    req_last_i[k]        = src_q[k][0][8];
                    req_data_i[k*8 +: 8] = src_q[k][0][7:0];
                end
            end
        end
    end

    task automatic expect_byte(input int k, input logic [7:0] d);
        exp_owner.push_back(k);
        exp_data.push_back(d);
    endtask

    task automatic enter_reset();
        rstn_i = 1'b0;
        #1;
        check_eq("rst_ready", 32'(req_ready_o), 32'(0));
        check_eq("rst_grant", 32'(grant_o), 32'(0));
        check_eq("rst_data", 32'(tx_data_o), 32'(0));
        check_eq("rst_start", 32'(tx_start_o), 32'(0));
        check_eq("rst_busy", 32'(busy_o), 32'(0));
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        exp_owner.delete();
        exp_data.delete();
        model_ptr = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        enter_reset();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  n = 0;
        bit  pending = 1'b1;
        while (pending && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
            pending = (exp_owner.size() != 0) || busy_o;
            for (int k = 0; k < NUM_REQ; k++) if (src_q[k].size() != 0) pending = 1'b1;
        end
        check_eq(tag, 32'(pending), 32'(0));
        repeat (4) @(negedge clk);
        #1;
        check_eq({tag, "_grant"}, 32'(grant_o), 32'(0));
    endtask

    task automatic wait_fall(input string tag);
        int f0 = fall_cnt;
        int n  = 0;
        while ((fall_cnt == f0) && (n < 300)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(fall_cnt != f0), 32'(1));
    endtask

    // Queue-level model: serve nonempty requesters round-robin; a grant ends on
    // a last byte, after MAX_BURST bytes, or when the requester runs dry (hold timeout)
    task automatic random_round(input int r);
        int k, n, npk, len;
        bit nolast, any;
        logic [8:0] e;
        for (int q = 0; q < NUM_REQ; q++) begin
            pend_q[q].delete();
            if ($urandom_range(0, 2) != 0) begin
                npk = $urandom_range(1, 2);
                for (int p = 0; p < npk; p++) begin
                    len    = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 22) : $urandom_range(1, 4);
                    nolast = (p == npk - 1) && ($urandom_range(0, 5) == 0);
                    for (int i = 0; i < len; i++)
                        pend_q[q].push_back({(i == len - 1) && !nolast, 8'($urandom)});
                end
            end
            mdl_q[q] = pend_q[q];
        end
        forever begin
            any = 1'b0;
            for (int q = 0; q < NUM_REQ; q++) if (mdl_q[q].size() != 0) any = 1'b1;
            if (!any) break;
            k = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                if ((k < 0) && (mdl_q[(model_ptr + i) % NUM_REQ].size() != 0))
                    k = (model_ptr + i) % NUM_REQ;
            end
            n = 0;
            forever begin
                e = mdl_q[k].pop_front();
                expect_byte(k, e[7:0]);
                n++;
                if (e[8] || (n == MAX_BURST) || (mdl_q[k].size() == 0)) break;
            end
            model_ptr = k;
        end
        for (int q = 0; q < NUM_REQ; q++) src_q[q] = pend_q[q];
        wait_idle($sformatf("rnd%0d_drain", r), 6000);
    endtask

    initial begin
        int s0, r0, g0, n;
        rstn_i      = 1'b0;
        req_data_i  = '0;
        req_valid_i = '0;
        req_last_i  = '0;
        tx_busy_i   = 1'b0;

        // Single requester, 3-byte packet; grant latency and busy_o tail
        do_reset();
        s0 = start_cnt;
        src_q[0].push_back({1'b0, 8'h41});
        src_q[0].push_back({1'b0, 8'h42});
        src_q[0].push_back({1'b1, 8'h43});
        expect_byte(0, 8'h41);
        expect_byte(0, 8'h42);
        expect_byte(0, 8'h43);
        @(negedge clk);
        check_eq("s1_grant_before", 32'(grant_o), 32'(0));
        @(negedge clk);
        check_eq("s1_grant_after", 32'(grant_o), 32'(1));
        wait_idle("s1_drain", 500);
        check_eq("s1_starts", 32'(start_cnt - s0), 32'(3));
        check_eq("s1_busy_tail", 32'(busyo_fall_cyc - fall_cyc), 32'(1));

        // Requesters 0 and 2 alternate on 1-byte packets
        do_reset();
        r0 = ready_pulses;
        g0 = grant_rises;
        src_q[0].push_back({1'b1, 8'h10});
        src_q[0].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h20});
        src_q[2].push_back({1'b1, 8'h21});
        expect_byte(0, 8'h10);
        expect_byte(2, 8'h20);
        expect_byte(0, 8'h11);
        expect_byte(2, 8'h21);
        wait_idle("s2_drain", 500);
        check_eq("s2_ready_pulses", 32'(ready_pulses - r0), 32'(4));
        check_eq("s2_grants", 32'(grant_rises - g0), 32'(4));

        // Burst limit: requester 1 sends 16 of 20, requester 3 gets a turn
        do_reset();
        for (int i = 0; i < 20; i++) src_q[1].push_back({i == 19, 8'(i)});
        src_q[3].push_back({1'b1, 8'hA0});
        for (int i = 0; i < 16; i++) expect_byte(1, 8'(i));
        expect_byte(3, 8'hA0);
        for (int i = 16; i < 20; i++) expect_byte(1, 8'(i));
        wait_idle("s3_drain", 2000);

        // Hold timeout: release 10 clocks into HOLD, then waiting requester 1
        do_reset();
        src_q[0].push_back({1'b0, 8'h55});
        src_q[1].push_back({1'b1, 8'h66});
        expect_byte(0, 8'h55);
        expect_byte(1, 8'h66);
        wait_fall("s4_fall");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((grant_o != '0) && (n < 40));
        check_eq("s4_release_delay", 32'(n), 32'(HOLD_CYCLES + 1));
        @(negedge clk);
        check_eq("s4_next_grant", 32'(grant_o), 32'(4'b0010));
        wait_idle("s4_drain", 500);

        // Valid gap inside HOLD keeps the grant; requester 2 waits
        do_reset();
        src_q[0].push_back({1'b0, 8'h71});
        src_q[2].push_back({1'b1, 8'h72});
        expect_byte(0, 8'h71);
        expect_byte(0, 8'h73);
        expect_byte(2, 8'h72);
        wait_fall("s5_fall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("s5_hold_grant", 32'(grant_o), 32'(1));
        end
        #1;
        src_q[0].push_back({1'b1, 8'h73});
        wait_idle("s5_drain", 500);

        // Reset during WAIT_DONE of byte 2, then a fresh arbitration
        do_reset();
        s0 = start_cnt;
        src_q[0].push_back({1'b0, 8'h81});
        src_q[0].push_back({1'b0, 8'h82});
        src_q[0].push_back({1'b1, 8'h83});
        expect_byte(0, 8'h81);
        expect_byte(0, 8'h82);
        expect_byte(0, 8'h83);
        n = 0;
        while ((start_cnt - s0 < 2) && (n < 300)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("s6_second_start", 32'(start_cnt - s0), 32'(2));
        @(negedge clk);
        #1;
        check_eq("s6_pending", 32'(exp_owner.size()), 32'(1));
        enter_reset();
        s0 = start_cnt;
        src_q[1].push_back({1'b1, 8'h92});
        src_q[0].push_back({1'b1, 8'h91});
        expect_byte(0, 8'h91);
        expect_byte(1, 8'h92);
        wait_idle("s6_drain", 500);
        check_eq("s6_starts_after", 32'(start_cnt - s0), 32'(2));

        // Randomized packet mixes; pointer carries over between rounds
        for (int r = 0; r < 12; r++) begin
            if ((r == 0) || ($urandom_range(0, 3) == 0)) do_reset();
            random_round(r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
